// File: rtl/carry_skip_pipe_adder.sv
// rtl/carry_skip_pipe_adder.sv - pipelined carry-skip adder/subtractor with valid/ready flow control.
// Optional signed-overflow output enabled by defining CSA_OVF_EN.
module carry_skip_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               cout,
  output logic [WIDTH/BLK-1:0] skip_mask
`ifdef CSA_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int NB  = WIDTH / BLK;
  localparam int BPS = (STAGES >= 1) ? NB / STAGES : 1;

  if ((STAGES < 1) || (WIDTH % BLK != 0) || ((STAGES >= 1) && (NB % STAGES != 0))) begin : g_bad_params
    $error("carry_skip_pipe_adder: illegal WIDTH/BLK/STAGES combination");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Stage inputs: index 0 from the ports, index s from register bank s-1.
  logic             v_in [STAGES];
  logic             c_in [STAGES];
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic [NB-1:0]    m_in [STAGES];

  logic             c_d  [STAGES];
  logic [WIDTH-1:0] s_d  [STAGES];
  logic [NB-1:0]    m_d  [STAGES];

  logic             v_q  [STAGES];
  logic             c_q  [STAGES];
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] s_q  [STAGES];
  logic [NB-1:0]    m_q  [STAGES];

`ifdef CSA_OVF_EN
  logic             msb_cin;
  logic             ovf_q;
`endif

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign b_eff    = b ^ {WIDTH{sub}};
  assign c0       = cin ^ sub;

  always_comb begin
    v_in[0] = in_valid;
    c_in[0] = c0;
    a_in[0] = a;
    b_in[0] = b_eff;
    s_in[0] = '0;
    m_in[0] = '0;
    for (int s = 1; s < STAGES; s++) begin
      v_in[s] = v_q[s-1];
      c_in[s] = c_q[s-1];
      a_in[s] = a_q[s-1];
      b_in[s] = b_q[s-1];
      s_in[s] = s_q[s-1];
      m_in[s] = m_q[s-1];
    end
  end

  always_comb begin : blk_carry_skip
    logic c;
    logic rc;
    logic p;
    logic x;
    int   bi;
    int   i;
    c  = 1'b0;
    rc = 1'b0;
    p  = 1'b0;
    x  = 1'b0;
    bi = 0;
    i  = 0;
`ifdef CSA_OVF_EN
    msb_cin = 1'b0;
`endif
    for (int s = 0; s < STAGES; s++) begin
      c      = c_in[s];
      s_d[s] = s_in[s];
      m_d[s] = m_in[s];
      for (int k = 0; k < BPS; k++) begin
        bi = s * BPS + k;
        rc = c;
        p  = 1'b1;
        for (int j = 0; j < BLK; j++) begin
          i         = bi * BLK + j;
          x         = a_in[s][i] ^ b_in[s][i];
          s_d[s][i] = x ^ rc;
`ifdef CSA_OVF_EN
          if (i == WIDTH - 1) msb_cin = rc;
`endif
          p  = p & x;
          rc = (a_in[s][i] & b_in[s][i]) | (rc & x);
        end
        m_d[s][bi] = p;
        // Skip mux selects the block carry-in directly, bypassing the ripple.
        c = p ? c : rc;
      end
      c_d[s] = c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s] <= 1'b0;
        c_q[s] <= 1'b0;
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
        m_q[s] <= '0;
      end
`ifdef CSA_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (en) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s] <= v_in[s];
        c_q[s] <= c_d[s];
        a_q[s] <= a_in[s];
        b_q[s] <= b_in[s];
        s_q[s] <= s_d[s];
        m_q[s] <= m_d[s];
      end
`ifdef CSA_OVF_EN
      ovf_q <= msb_cin ^ c_d[STAGES-1];
`endif
    end
  end

  // Operand bits left in the final bank are fully consumed.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1]};

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign skip_mask = m_q[STAGES-1];
`ifdef CSA_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_carry_skip_pipe_adder.sv
// tb/tb_carry_skip_pipe_adder.sv - directed and random checks of carry_skip_pipe_adder.
// Checks ovf as well when CSA_OVF_EN is defined.
module tb_carry_skip_pipe_adder;
  localparam int W  = 16;
  localparam int B  = 4;
  localparam int S  = 2;
  localparam int NB = W / B;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic [NB-1:0] skip_mask;
`ifdef CSA_OVF_EN
  logic          ovf;
`endif

  always #5 clk = ~clk;

  carry_skip_pipe_adder #(.WIDTH(W), .BLK(B), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .skip_mask (skip_mask)
`ifdef CSA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic [W-1:0]  sum;
    logic          cout;
    logic [NB-1:0] mask;
    logic          ovf;
  } vec_t;

  vec_t tv [11];
  vec_t beats [$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NB+W:0] model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                          input logic ci, input logic si);
    logic [W-1:0]  be;
    logic [W-1:0]  x;
    logic [W:0]    r;
    logic [NB-1:0] m;
    be = bi ^ {W{si}};
    r  = {1'b0, ai} + {1'b0, be} + {{W{1'b0}}, ci ^ si};
    x  = ai ^ be;
    for (int k = 0; k < NB; k++) m[k] = &x[k*B +: B];
    return {m, r};
  endfunction

  task automatic drive(input vec_t v);
    a   = v.a;
    b   = v.b;
    cin = v.cin;
    sub = v.sub;
  endtask

  // mode 0: out_ready high; mode 1: 3-cycle stall on first result; mode 2: random out_ready
  task automatic run_stream(input int mode, input string tag);
    int               n;
    int               idx;
    int               got;
    int               stall;
    bit               stall_done;
    bit               held;
    bit               accepted;
    logic [W-1:0]     p_sum;
    logic             p_cout;
    logic [NB-1:0]    p_mask;
    logic [NB+W:0]    e;
    n = beats.size();
    idx = 0; got = 0; stall = 0; stall_done = 0; held = 0;
    p_sum = '0; p_cout = 1'b0; p_mask = '0;
    for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
      in_valid = (idx < n);
      if (idx < n) drive(beats[idx]);
      if (mode == 1 && out_valid && !stall_done) begin
        stall = 3;
        stall_done = 1;
      end
      if (mode == 2) out_ready = ($urandom_range(0, 9) < 7);
      else           out_ready = (stall == 0);
      if (stall > 0) stall--;
      #1;
      if (held) begin
        chk({tag, " hold_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, " hold_sum"}, {16'b0, sum}, {16'b0, p_sum});
        chk({tag, " hold_cout"}, {31'b0, cout}, {31'b0, p_cout});
        chk({tag, " hold_mask"}, {28'b0, skip_mask}, {28'b0, p_mask});
      end
      if (mode == 1 && !out_ready) chk({tag, " in_ready_stall"}, {31'b0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        e = model(beats[got].a, beats[got].b, beats[got].cin, beats[got].sub);
        chk($sformatf("%s[%0d] sum", tag, got), {16'b0, sum}, {16'b0, e[W-1:0]});
        chk($sformatf("%s[%0d] cout", tag, got), {31'b0, cout}, {31'b0, e[W]});
        chk($sformatf("%s[%0d] mask", tag, got), {28'b0, skip_mask}, {28'b0, e[NB+W:W+1]});
        if (mode == 0 && got == n - 1) chk({tag, " throughput"}, cyc, n - 1 + S);
        got++;
        n_vec++;
      end
      held     = out_valid && !out_ready;
      p_sum    = sum;
      p_cout   = cout;
      p_mask   = skip_mask;
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, " delivered"}, got, n);
    if (mode == 1) chk({tag, " stall_seen"}, {31'b0, stall_done}, 32'd1);
    repeat (S + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    int   lat;
    int   stale;
    vec_t r;
    tv[0]  = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 4'b0110, 1'b0};
    tv[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 4'b1111, 1'b0};
    tv[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 4'b1110, 1'b0};
    tv[3]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 4'b1110, 1'b0};
    tv[4]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 4'b0000, 1'b0};
    tv[5]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b1110, 1'b0};
    tv[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 4'b0110, 1'b1};
    tv[7]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 4'b0110, 1'b1};
    tv[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 4'b1111, 1'b0};
    tv[9]  = '{16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b1, 4'b1110, 1'b0};
    tv[10] = '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 4'b0010, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst sum", {16'b0, sum}, 32'd0);
    chk("rst cout", {31'b0, cout}, 32'd0);
    chk("rst mask", {28'b0, skip_mask}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      drive(tv[i]);
      in_valid = 1'b1;
      #1;
      chk($sformatf("tv%0d in_ready", i), {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("tv%0d latency", i), lat, S);
      chk($sformatf("tv%0d sum", i), {16'b0, sum}, {16'b0, tv[i].sum});
      chk($sformatf("tv%0d cout", i), {31'b0, cout}, {31'b0, tv[i].cout});
      chk($sformatf("tv%0d mask", i), {28'b0, skip_mask}, {28'b0, tv[i].mask});
`ifdef CSA_OVF_EN
      chk($sformatf("tv%0d ovf", i), {31'b0, ovf}, {31'b0, tv[i].ovf});
`endif
      n_vec++;
    end
    @(posedge clk); #1;
    chk("drain out_valid", {31'b0, out_valid}, 32'd0);

    beats.delete();
    for (int i = 0; i < 11; i++) beats.push_back(tv[i]);
    run_stream(0, "b2b");

    beats.delete();
    for (int i = 0; i < 4; i++) beats.push_back(tv[i]);
    run_stream(1, "bp");

    beats.delete();
    for (int i = 0; i < 24; i++) begin
      r.a = W'($urandom); r.b = W'($urandom);
      r.cin = 1'($urandom); r.sub = 1'($urandom);
      r.sum = '0; r.cout = 1'b0; r.mask = '0; r.ovf = 1'b0;
      beats.push_back(r);
    end
    run_stream(2, "rnd");

    drive(tv[0]); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    drive(tv[10]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid out_valid pre", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid rst sum", {16'b0, sum}, 32'd0);
    chk("mid rst cout", {31'b0, cout}, 32'd0);
    chk("mid rst mask", {28'b0, skip_mask}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("mid rst stale", stale, 0);
    chk("mid rst in_ready", {31'b0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
